// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers (square output and/or one-cycle tick per channel).
// Outputs come straight from flops; a write or sync restarts phase so the first event lands D edges later.
`timescale 1ns/1ps
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = 50000,
  parameter int CH_W        = 2
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic              wr_mode,
  input  logic              wr_chen,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] chen_q;
  logic [NUM_CH-1:0] hit;

  // An out-of-range wr_ch matches no channel, so the write is dropped.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = wr_en && (wr_ch == CH_W'(i));
    end
  end

  always_ff @(posedge sysclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        div_q[i]   <= CNT_W'(DEFAULT_DIV);
        mode_q[i]  <= 1'b0;
        chen_q[i]  <= 1'b1;
        cnt_q[i]   <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end else begin
        if (hit[i]) begin
          div_q[i]  <= wr_div;
          mode_q[i] <= wr_mode;
          chen_q[i] <= wr_chen;
        end
        if (sync || hit[i]) begin
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (chen_q[i] && (div_q[i] != '0)) begin
          if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
            cnt_q[i]   <= '0;
            tick[i]    <= 1'b1;
            clk_out[i] <= ~clk_out[i] & ~mode_q[i];
          end else begin
            cnt_q[i]   <= cnt_q[i] + CNT_W'(1);
            tick[i]    <= 1'b0;
            clk_out[i] <= clk_out[i] & ~mode_q[i];
          end
        end else begin
          cnt_q[i]   <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboarded bench for clk_div_bank: stimulus queues expected output snapshots, a monitor compares them.
`timescale 1ns/1ps
module tb_clk_div_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DD  = 5;
  localparam int CHW = 3;

  logic           sysclk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [CW-1:0]  wr_div = '0;
  logic           wr_mode = 1'b0;
  logic           wr_chen = 1'b0;
  logic           sync = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DD), .CH_W(CHW)) dut (
    .sysclk(sysclk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .wr_mode(wr_mode), .wr_chen(wr_chen), .sync(sync), .clk_out(clk_out), .tick(tick)
  );

  always #5 sysclk = ~sysclk;

  int edge_cnt = 0;
  always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] msk;
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tk;
    string          name;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  // Reference: per channel, the edge its phase restarted and its configuration.
  int t0[NCH];
  int dm[NCH];
  bit mm[NCH];
  bit em[NCH];

  function automatic logic [1:0] model_bits(int ch, int n);
    int   m;
    logic c;
    logic t;
    m = n - t0[ch];
    if (!em[ch] || dm[ch] == 0 || m <= 0) return 2'b00;
    t = ((m % dm[ch]) == 0);
    c = !mm[ch] && (((m / dm[ch]) % 2) == 1);
    return {c, t};
  endfunction

  // Monitor: outputs are sampled on the falling edge, half a cycle after they update.
  always @(negedge sysclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != edge_cnt ||
          (((clk_out ^ e.clk) & e.msk) !== '0) ||
          (((tick ^ e.tk) & e.msk) !== '0)) begin
        failures++;
        $display("FAIL %s edge=%0d(exp %0d) clk_out=%b tick=%b required clk_out=%b tick=%b mask=%b",
                 e.name, edge_cnt, e.cyc, clk_out, tick, e.clk, e.tk, e.msk);
      end
    end
  end

  // Called at a falling edge; the inputs are sampled at the next rising edge.
  task automatic step(input logic r, input logic we, input logic [CHW-1:0] ch,
                      input logic [CW-1:0] dv, input logic md, input logic en, input logic sy);
    exp_t       e;
    int         n;
    logic [1:0] b;
    rst = r; wr_en = we; wr_ch = ch; wr_div = dv; wr_mode = md; wr_chen = en; sync = sy;
    n = edge_cnt + 1;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        t0[i] = n; dm[i] = DD; mm[i] = 1'b0; em[i] = 1'b1;
      end
    end else begin
      if (we && ch < NCH) begin
        t0[ch] = n; dm[ch] = dv; mm[ch] = md; em[ch] = en;
      end
      if (sy) for (int i = 0; i < NCH; i++) t0[i] = n;
    end
    e.cyc = n; e.msk = '1; e.name = phase;
    for (int i = 0; i < NCH; i++) begin
      b = model_bits(i, n);
      e.clk[i] = b[1];
      e.tk[i]  = b[0];
    end
    exp_q.push_back(e);
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [CHW-1:0] ch, input logic [CW-1:0] dv, input logic md, input logic en);
    step(1'b0, 1'b1, ch, dv, md, en, 1'b0);
  endtask

  // Hand-computed snapshot for the next rising edge, checked only on masked channels.
  task automatic lit(input string nm, input logic [NCH-1:0] msk,
                     input logic [NCH-1:0] c, input logic [NCH-1:0] t);
    exp_t e;
    e.cyc = edge_cnt + 1; e.msk = msk; e.clk = c; e.tk = t; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge sysclk);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    phase = "reset_default";
    idle(4);
    lit("rst_first_event", 4'hF, 4'hF, 4'hF); idle(1);
    lit("rst_tick_drop",   4'hF, 4'hF, 4'h0); idle(1);
    idle(3);
    lit("rst_second_event", 4'hF, 4'h0, 4'hF); idle(1);
    idle(12);

    phase = "mode_write";
    wr(3'd1, 8'd3, 1'b1, 1'b1);
    idle(2);
    lit("mode_t3", 4'hF, 4'b1101, 4'b0010); idle(1);
    idle(3);
    lit("mode_t7", 4'hF, 4'b0000, 4'b1101); idle(1);
    idle(3);

    phase = "div_one";
    wr(3'd2, 8'd1, 1'b0, 1'b1);
    lit("d1_first", 4'b0100, 4'b0100, 4'b0100); idle(1);
    lit("d1_second", 4'b0100, 4'b0000, 4'b0100); idle(1);
    idle(3);
    phase = "div_zero";
    wr(3'd2, 8'd0, 1'b0, 1'b1);
    lit("d0_quiet", 4'b0100, 4'b0000, 4'b0000); idle(1);
    idle(2);
    phase = "div_max";
    wr(3'd3, 8'd255, 1'b0, 1'b1);
    idle(254);
    lit("d255_rise", 4'b1000, 4'b1000, 4'b1000); idle(1);
    idle(254);
    lit("d255_fall", 4'b1000, 4'b0000, 4'b1000); idle(1);
    idle(5);

    phase = "sync";
    wr(3'd0, 8'd4, 1'b0, 1'b1);
    wr(3'd1, 8'd6, 1'b0, 1'b1);
    idle(7);
    step(1'b0, 1'b1, 3'd2, 8'd2, 1'b0, 1'b1, 1'b1);
    idle(1);
    lit("sync_ch2", 4'b0100, 4'b0100, 4'b0100); idle(1);
    idle(1);
    lit("sync_ch0", 4'b0101, 4'b0001, 4'b0101); idle(1);
    idle(1);
    lit("sync_ch1", 4'b0111, 4'b0111, 4'b0110); idle(1);
    idle(4);

    phase = "bad_index";
    wr(3'd5, 8'd1, 1'b1, 1'b0);
    idle(6);
    phase = "disable";
    lit("disable_ch0", 4'b0001, 4'b0000, 4'b0000);
    wr(3'd0, 8'd5, 1'b0, 1'b0);
    idle(3);
    phase = "reenable";
    wr(3'd0, 8'd5, 1'b0, 1'b1);
    idle(4);
    lit("reen_event", 4'b0001, 4'b0001, 4'b0001); idle(1);
    idle(2);

    phase = "reset_mid";
    lit("rst_mid_zero", 4'hF, 4'h0, 4'h0);
    step(1'b1, 1'b1, 3'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    phase = "reset_after";
    idle(4);
    lit("rst2_first_event", 4'hF, 4'hF, 4'hF); idle(1);
    idle(6);

    @(posedge sysclk);
    @(negedge sysclk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
